// File: rtl/seven_seg_pkg.sv
// Shared display-code constants for the seven-segment path.
// Codes above 9 are the non-numeric glyphs the status logic uses.
package seven_seg_pkg;

    localparam logic [3:0] CODE_DASH = 4'ha;
    localparam logic [3:0] CODE_F    = 4'hb;
    localparam logic [3:0] CODE_C    = 4'hc;
    localparam logic [3:0] CODE_N    = 4'hd;
    localparam logic [3:0] CODE_D    = 4'he;
    localparam logic [3:0] CODE_U    = 4'hf;

    // Decimal points are active-low on the board.
    localparam logic DP_OFF = 1'b1;

endpackage

// File: rtl/slot_timer.sv
// Slot prescaler plus digit index for the display scanner.
// count runs 0..PRESCALE-1 per slot; index advances on each slot wrap and
// itself wraps NDIGITS-1 -> 0. frameWrap is high in the cycle whose edge
// performs that index wrap. Dropping enable parks both counters at zero.
module slot_timer #(
    parameter int NDIGITS  = 8,
    parameter int PRESCALE = 100000,
    localparam int CW = $clog2(PRESCALE),
    localparam int IW = $clog2(NDIGITS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic [IW-1:0] index,
    output logic          frameWrap
);

    localparam logic [CW-1:0] LAST_COUNT = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] LAST_INDEX = IW'(NDIGITS - 1);

    logic slotWrap;

    // Wrap pulses are decoded from the current state so the next edge acts on them.
    always_comb begin
        slotWrap  = enable && (count == LAST_COUNT);
        frameWrap = slotWrap && (index == LAST_INDEX);
    end

    // Prescaler and digit index; disabled scan restarts from digit 0, count 0.
    always_ff @(posedge clk) begin
        if (rst || !enable) begin
            count <= '0;
            index <= '0;
        end else if (slotWrap) begin
            count <= '0;
            index <= (index == LAST_INDEX) ? '0 : index + 1'b1;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scanner for an NDIGITS seven-segment display.
// Display contents are double-buffered: load writes a staging copy, and the
// shown copy is refreshed only at a frame boundary so a frame never tears.
// Outputs are registered from the timer state, so they trail it by one edge.
//
// load handshake: single-cycle strobe with no ready/back-pressure. Every edge
// with load = 1 captures digits/dps/blank; a second load before the frame
// boundary simply replaces the staged values (last load wins). pending is
// high from the capturing edge until the boundary edge that shows the data.
module seven_segment_scanner
    import seven_seg_pkg::*;
#(
    parameter int NDIGITS  = 8,
    parameter int PRESCALE = 100000,
    parameter int BLANK    = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4*NDIGITS-1:0] digits,
    input  logic [NDIGITS-1:0]   dps,
    input  logic [NDIGITS-1:0]   blank,
    input  logic                 load,
    input  logic                 enable,
    output logic [3:0]           BCD,
    output logic                 dp,
    output logic [NDIGITS-1:0]   AN,
    output logic                 pending
);

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(NDIGITS);
    localparam logic [CW-1:0] BLANK_COUNT = CW'(BLANK);

    logic [CW-1:0]          count;
    logic [IW-1:0]          index;
    logic                   frameWrap;
    logic                   frameBoundary;

    logic [4*NDIGITS-1:0]   stageCodes;
    logic [NDIGITS-1:0]     stageDps;
    logic [NDIGITS-1:0]     stageBlank;
    logic [4*NDIGITS-1:0]   dispCodes;
    logic [NDIGITS-1:0]     dispDps;
    logic [NDIGITS-1:0]     dispBlank;

    logic [NDIGITS-1:0]     anNext;

    slot_timer #(
        .NDIGITS  (NDIGITS),
        .PRESCALE (PRESCALE)
    ) u_slot_timer (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .count     (count),
        .index     (index),
        .frameWrap (frameWrap)
    );

    // A disabled scanner sits at the restart point, which counts as a frame boundary.
    always_comb begin
        frameBoundary = frameWrap || !enable;
    end

    // Staging capture and frame-boundary swap into the shown copy.
    always_ff @(posedge clk) begin
        if (rst) begin
            stageCodes <= {NDIGITS{CODE_DASH}};
            stageDps   <= {NDIGITS{DP_OFF}};
            stageBlank <= '0;
            dispCodes  <= {NDIGITS{CODE_DASH}};
            dispDps    <= {NDIGITS{DP_OFF}};
            dispBlank  <= '0;
            pending    <= 1'b0;
        end else begin
            if (load) begin
                stageCodes <= digits;
                stageDps   <= dps;
                stageBlank <= blank;
            end
            if (frameBoundary) begin
                // A load landing on the boundary goes straight to the display.
                if (load) begin
                    dispCodes <= digits;
                    dispDps   <= dps;
                    dispBlank <= blank;
                end else if (pending) begin
                    dispCodes <= stageCodes;
                    dispDps   <= stageDps;
                    dispBlank <= stageBlank;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    // Anode pattern for the current count: dark during dead time or when blanked.
    always_comb begin
        anNext = '1;
        if ((count >= BLANK_COUNT) && !dispBlank[index]) begin
            anNext[index] = 1'b0;
        end
    end

    // Registered drive to the decoder and anodes; code/dp change only at slot start.
    always_ff @(posedge clk) begin
        if (rst) begin
            AN  <= '1;
            BCD <= CODE_DASH;
            dp  <= DP_OFF;
        end else if (!enable) begin
            AN <= '1;
        end else begin
            AN <= anNext;
            if (count == '0) begin
                BCD <= dispCodes[{index, 2'b00} +: 4];
                dp  <= dispDps[index];
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Table-driven bench for seven_segment_scanner with NDIGITS=4, PRESCALE=8,
// BLANK=2. Each record holds inputs for a run of cycles and the outputs
// expected after every edge of that run; load is pulsed on the first edge.
module tb_seven_segment_scanner;

    localparam int NDIGITS  = 4;
    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] digits;
    logic [3:0]  dps;
    logic [3:0]  blank;
    logic        load;
    logic        enable;
    logic [3:0]  BCD;
    logic        dp;
    logic [3:0]  AN;
    logic        pending;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic        rst;
        logic        enable;
        logic        load;
        logic [15:0] digits;
        logic [3:0]  dps;
        logic [3:0]  blank;
        int          cycles;
        logic [3:0]  expAn;
        logic [3:0]  expBcd;
        logic        expDp;
        logic        expPending;
        logic        chkCode;
    } vec_t;

    vec_t vecs[$];

    seven_segment_scanner #(
        .NDIGITS  (NDIGITS),
        .PRESCALE (PRESCALE),
        .BLANK    (BLANK)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .digits  (digits),
        .dps     (dps),
        .blank   (blank),
        .load    (load),
        .enable  (enable),
        .BCD     (BCD),
        .dp      (dp),
        .AN      (AN),
        .pending (pending)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1);
    end

    // Driver helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int vi, input int cyc,
                         input logic [3:0] got, input logic [3:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s vec%0d cyc%0d got %h want %h", name, vi, cyc, got, want);
        end
    endtask

    task automatic addVec(input logic r, input logic e, input logic l,
                          input logic [15:0] d, input logic [3:0] p, input logic [3:0] b,
                          input int n, input logic [3:0] an, input logic [3:0] bcd,
                          input logic dpv, input logic pend, input logic chk);
        vec_t t;
        t.rst = r; t.enable = e; t.load = l;
        t.digits = d; t.dps = p; t.blank = b;
        t.cycles = n; t.expAn = an; t.expBcd = bcd;
        t.expDp = dpv; t.expPending = pend; t.chkCode = chk;
        vecs.push_back(t);
    endtask

    // Plain running record: out of reset, enabled, no load.
    task automatic run(input int n, input logic [3:0] an, input logic [3:0] bcd,
                       input logic dpv, input logic pend);
        addVec(1'b0, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, n, an, bcd, dpv, pend, 1'b1);
    endtask

    initial begin
        // Reset, then first frame of dashes with 2-cycle dead time per slot.
        addVec(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 3, 4'hF, 4'ha, 1'b1, 1'b0, 1'b1);
        run(2, 4'hF, 4'ha, 1'b1, 1'b0);
        run(6, 4'hE, 4'ha, 1'b1, 1'b0);
        run(2, 4'hF, 4'ha, 1'b1, 1'b0);
        run(6, 4'hD, 4'ha, 1'b1, 1'b0);
        run(2, 4'hF, 4'ha, 1'b1, 1'b0);
        run(6, 4'hB, 4'ha, 1'b1, 1'b0);
        run(2, 4'hF, 4'ha, 1'b1, 1'b0);
        run(6, 4'h7, 4'ha, 1'b1, 1'b0);
        // Mid-frame load: dashes continue, pending until the wrap edge.
        addVec(1'b0, 1'b1, 1'b1, 16'h1234, 4'b1110, 4'b0000, 2, 4'hF, 4'ha, 1'b1, 1'b1, 1'b1);
        run(6, 4'hE, 4'ha, 1'b1, 1'b1);
        run(2, 4'hF, 4'ha, 1'b1, 1'b1);
        run(6, 4'hD, 4'ha, 1'b1, 1'b1);
        run(2, 4'hF, 4'ha, 1'b1, 1'b1);
        run(6, 4'hB, 4'ha, 1'b1, 1'b1);
        run(2, 4'hF, 4'ha, 1'b1, 1'b1);
        run(5, 4'h7, 4'ha, 1'b1, 1'b1);
        run(1, 4'h7, 4'ha, 1'b1, 1'b0);
        // Frame showing 1234 with dp on digit 0.
        run(2, 4'hF, 4'h4, 1'b0, 1'b0);
        run(6, 4'hE, 4'h4, 1'b0, 1'b0);
        run(2, 4'hF, 4'h3, 1'b1, 1'b0);
        run(6, 4'hD, 4'h3, 1'b1, 1'b0);
        run(2, 4'hF, 4'h2, 1'b1, 1'b0);
        run(6, 4'hB, 4'h2, 1'b1, 1'b0);
        run(2, 4'hF, 4'h1, 1'b1, 1'b0);
        run(5, 4'h7, 4'h1, 1'b1, 1'b0);
        // Load exactly on the wrap edge: bypass, pending never set; digit 1 blanked.
        addVec(1'b0, 1'b1, 1'b1, 16'hbcde, 4'b0111, 4'b0010, 1, 4'h7, 4'h1, 1'b1, 1'b0, 1'b1);
        run(2, 4'hF, 4'he, 1'b1, 1'b0);
        run(6, 4'hE, 4'he, 1'b1, 1'b0);
        run(2, 4'hF, 4'hd, 1'b1, 1'b0);
        run(6, 4'hF, 4'hd, 1'b1, 1'b0);
        run(2, 4'hF, 4'hc, 1'b1, 1'b0);
        run(6, 4'hB, 4'hc, 1'b1, 1'b0);
        run(2, 4'hF, 4'hb, 1'b0, 1'b0);
        run(6, 4'h7, 4'hb, 1'b0, 1'b0);
        run(2, 4'hF, 4'he, 1'b1, 1'b0);
        run(6, 4'hE, 4'he, 1'b1, 1'b0);
        run(2, 4'hF, 4'hd, 1'b1, 1'b0);
        run(6, 4'hF, 4'hd, 1'b1, 1'b0);
        run(2, 4'hF, 4'hc, 1'b1, 1'b0);
        // Load in slot 2, then drop enable: anodes off, staged data taken at once.
        addVec(1'b0, 1'b1, 1'b1, 16'h5678, 4'b1111, 4'b0000, 3, 4'hB, 4'hc, 1'b1, 1'b1, 1'b1);
        addVec(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 1, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        addVec(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 4'h0, 2, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0);
        // Re-enable: slot 0 restarts with dead time, AN[0] low on the third edge.
        run(2, 4'hF, 4'h8, 1'b1, 1'b0);
        run(6, 4'hE, 4'h8, 1'b1, 1'b0);
        run(2, 4'hF, 4'h7, 1'b1, 1'b0);
        // Stage data, then reset mid-frame: pending data discarded.
        addVec(1'b0, 1'b1, 1'b1, 16'h9999, 4'b0000, 4'b1111, 2, 4'hD, 4'h7, 1'b1, 1'b1, 1'b1);
        addVec(1'b1, 1'b1, 1'b0, 16'h0, 4'h0, 4'h0, 2, 4'hF, 4'ha, 1'b1, 1'b0, 1'b1);
        run(2, 4'hF, 4'ha, 1'b1, 1'b0);
        run(6, 4'hE, 4'ha, 1'b1, 1'b0);
        run(2, 4'hF, 4'ha, 1'b1, 1'b0);
        run(6, 4'hD, 4'ha, 1'b1, 1'b0);
        run(2, 4'hF, 4'ha, 1'b1, 1'b0);
        run(6, 4'hB, 4'ha, 1'b1, 1'b0);
        run(2, 4'hF, 4'ha, 1'b1, 1'b0);
        run(6, 4'h7, 4'ha, 1'b1, 1'b0);
        run(2, 4'hF, 4'ha, 1'b1, 1'b0);

        rst = 1'b1; enable = 1'b1; load = 1'b0;
        digits = '0; dps = '0; blank = '0;

        // Apply the table
        for (int i = 0; i < vecs.size(); i++) begin
            rst    = vecs[i].rst;
            enable = vecs[i].enable;
            load   = vecs[i].load;
            digits = vecs[i].digits;
            dps    = vecs[i].dps;
            blank  = vecs[i].blank;
            for (int n = 0; n < vecs[i].cycles; n++) begin
                step();
                load = 1'b0;
                check("AN", i, n, AN, vecs[i].expAn);
                check("pending", i, n, {3'b000, pending}, {3'b000, vecs[i].expPending});
                if (vecs[i].chkCode) begin
                    check("BCD", i, n, BCD, vecs[i].expBcd);
                    check("dp", i, n, {3'b000, dp}, {3'b000, vecs[i].expDp});
                end
            end
        end

        // Hand sequence: two loads in one frame, the second one is shown.
        // Scan now sits at slot 0, count 2.
        rst = 1'b0; enable = 1'b1;
        digits = 16'h1111; dps = 4'b1111; blank = 4'b0000; load = 1'b1;
        step();
        check("pend_first_load", 100, 0, {3'b000, pending}, 4'h1);
        digits = 16'h4321; dps = 4'b1010; blank = 4'b0000; load = 1'b1;
        step();
        load = 1'b0;
        check("pend_second_load", 100, 1, {3'b000, pending}, 4'h1);
        // 28 edges to reach and perform the frame wrap (slot 0 count 4..7, slots 1..3).
        for (int n = 0; n < 27; n++) step();
        check("pend_before_wrap", 100, 2, {3'b000, pending}, 4'h1);
        step();
        check("pend_after_wrap", 100, 3, {3'b000, pending}, 4'h0);
        step();
        check("lastwins_bcd0", 100, 4, BCD, 4'h1);
        check("lastwins_dp0", 100, 4, {3'b000, dp}, 4'h0);
        check("lastwins_an_dead", 100, 4, AN, 4'hF);
        step();
        step();
        check("lastwins_an0", 100, 5, AN, 4'hE);
        for (int n = 0; n < 6; n++) step();
        check("lastwins_bcd1", 100, 6, BCD, 4'h2);
        check("lastwins_dp1", 100, 6, {3'b000, dp}, 4'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/seven_segment_scanner.md
# seven_segment_scanner

Time-multiplexed digit scanner that feeds the shared seven-segment decoder. Holds NDIGITS 4-bit display codes plus decimal points, cycles one digit at a time at a fixed refresh rate, and drives the BCD/dp inputs of the decoder together with the active-low digit anodes. Display contents are double-buffered so a new value never tears mid-frame. It sits between the RSA control/status logic (producer of codes such as 4'ha dash, 4'hb F, 4'hd n) and the board display.

## Interface
- NDIGITS, 8, number of multiplexed digits (≥2)
- PRESCALE, 100000, clock cycles per digit slot (≥2); 1 kHz per digit at 100 MHz
- BLANK, 1000, dead-time cycles at the start of each slot with all anodes off (0 ≤ BLANK < PRESCALE)
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- digits  in  4*NDIGITS  display codes; digit k = digits[4k+3:4k]
- dps  in  NDIGITS  decimal points, active-low (0 = lit), digit k = dps[k]
- blank  in  NDIGITS  per-digit blank mask (1 = digit dark for whole slot)
- load  in  1  single-cycle strobe; capture digits/dps/blank
- enable  in  1  0 = all anodes off, scan held at restart
- BCD  out  4  code of the current digit, to the decoder
- dp  out  1  decimal point of the current digit, to the decoder
- AN  out  NDIGITS  anodes, active-low, one-hot-low or all-ones
- pending  out  1  staged data not yet shown

## Operation
- Reset values: AN all ones, BCD = 4'ha, dp = 1, pending = 0; staging and display registers = all 4'ha codes, dps all 1, blank all 0; slot counter 0, digit index 0.
- load: digits/dps/blank captured into staging on that edge; pending set to 1.
- Display register updated from staging only at frame boundary (index wraps NDIGITS-1 → 0); pending cleared on that edge.
- load coincident with the wrap edge: display register takes the input values directly (bypass), pending stays 0.
- load while pending = 1: staging overwritten, last load wins.
- Slot counter counts 0..PRESCALE-1, then wraps and advances the digit index; index wraps NDIGITS-1 → 0.
- Per slot k: BCD/dp take display code k at count 0; AN all ones for count 0..BLANK-1; AN[k] low for count BLANK..PRESCALE-1 unless blank[k] = 1 (stays high).
- enable = 0: AN all ones next edge; counter and index forced to 0; wrap-time display update still performed immediately if pending. enable rising: scan restarts at digit 0, count 0 (dead time included).
- rst mid-frame: all state to reset values; pending data discarded.

## Timing
- All outputs registered; no combinational input→output path.
- Slot = PRESCALE cycles; frame = NDIGITS*PRESCALE cycles; dead time exactly BLANK cycles per slot.
- Outputs lag counter state by one edge: after rst falls with enable = 1, AN[0] first low after edge BLANK+1, held PRESCALE-BLANK cycles.
- BCD/dp change only while AN is all ones (BLANK ≥ 1) → no ghosting; with BLANK = 0 they change on the same edge as AN.
- load → visible: at most one frame plus one slot.

## Structure
- Shared package seven_seg_pkg: display-code constants (CODE_DASH = 4'ha, CODE_F = 4'hb, CODE_C = 4'hc, CODE_N = 4'hd, CODE_D = 4'he, CODE_U = 4'hf), DP_OFF = 1'b1.
- One sub-module: slot_timer (prescaler + digit index, emits count and wrap pulses).
- Scanner does not instantiate the decoder; top level wires BCD/dp to it.

## Test plan
(NDIGITS = 4, PRESCALE = 8, BLANK = 2)
- Reset 3 cycles, enable = 1 → AN = 4'b1111, BCD = 4'ha, dp = 1, pending = 0; then AN = 4'b1110 for 6 cycles, 1111 for 2, 4'b1101 for 6, …, wrap back to 1110.
- load digits = 16'h1234, dps = 4'b1110 mid-frame → pending = 1, dashes continue; after wrap slot 0 shows BCD = 4, dp = 0, slot 3 BCD = 1; pending = 0.
- load digits = 16'hbcde on the wrap edge → slot 0 immediately BCD = 4'he, pending never set.
- blank = 4'b0010 → AN[1] never low, slot timing of others unchanged, frame still 32 cycles.
- enable dropped in slot 2 → AN = 1111 next edge; re-enable → AN[0] low after 3 edges, slot 0 restarts.
- rst asserted with pending = 1 → all reset values; after release dashes shown, staged data lost.
